maj_chain_sched: RTL and testbench
==================================

MAJ_CHAIN_SCHED -- requirements
Module: maj_chain_sched

Interface
REQ-001 SHALL have parameter W, default 11, giving the majority-chain length in stages (operand width); legal range 1..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, requester i presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 each, requester i's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a / req1_a and req0_b / req1_b, input, W each, per-stage majority operands.
REQ-007 SHALL have ports req0_c0 / req1_c0 and req0_t / req1_t, input, 1 each, chain seed and final XOR term.
REQ-008 SHALL have port rsp_valid, output, 1, result available.
REQ-009 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port rsp_data, output, 1, result t XOR final carry.
REQ-011 SHALL have port rsp_id, output, 1, index of the requester that owns rsp_data.

Function
REQ-012 SHALL evaluate c(k+1) = MAJ(a[k], c(k), b[k]) for k = 0..W-1, with c(0) = c0, and rsp_data = t XOR c(W).
REQ-013 SHALL time-share one MAJ3 stage: exactly one chain stage is evaluated per cycle.
REQ-014 SHALL implement states IDLE, EVAL, RESP; IDLE -> EVAL on accept, EVAL -> RESP after stage W-1, RESP -> IDLE on rsp_valid && rsp_ready.
REQ-015 SHALL drive reqi_ready combinationally: 1 only in IDLE for the granted requester; never both at once.
REQ-016 SHALL capture a, b, c0, t and the requester id in the cycle reqi_valid && reqi_ready holds; later input changes do not affect the operation.
REQ-017 SHALL assert rsp_valid exactly W+1 cycles after the accept edge, for example 12 cycles when W = 11.
REQ-018 SHALL hold rsp_valid, rsp_data and rsp_id stable while rsp_valid && !rsp_ready.
REQ-019 SHALL not accept a new request in the cycle a response is consumed; the earliest next accept is one cycle after the RESP -> IDLE transition.
REQ-020 SHALL, with W = 1, spend exactly one EVAL cycle.
REQ-021 SHALL ignore reqi_valid while in EVAL or RESP; a requester may change its valid before being accepted without error.

Reset
REQ-022 SHALL, when rst_n = 0 at a clock edge, enter IDLE, clear the stage index and carry, and drive rsp_valid = 0, rsp_data = 0, rsp_id = 0, req0_ready = req1_ready = 0.
REQ-023 SHALL, when reset occurs mid-operation (EVAL or RESP), discard that operation with no response ever issued.
REQ-024 SHALL, after reset, give the round-robin pointer (if present) priority to requester 0.

Configuration
REQ-025 SHALL, with MAJ_CHAIN_SCHED_RR_EN defined, arbitrate round-robin: on simultaneous valid, the requester not granted most recently wins, and the pointer updates only on accept.
REQ-026 SHALL, without MAJ_CHAIN_SCHED_RR_EN, use fixed priority: requester 0 always wins on simultaneous valid.

Structure
REQ-027 SHALL place the state enum (IDLE/EVAL/RESP), the default W and the requester-id type in shared package maj_chain_sched_pkg.
REQ-028 SHALL instantiate exactly one sub-module maj3_stage, a combinational MAJ3 with registered carry handled by the parent; no other sub-modules.

Verification
REQ-029 SHALL, for W = 11, req0 with a = 11'h7FF, b = 0, c0 = 0, t = 0 (no req1), produce rsp_valid at cycle 12, rsp_data = 0, rsp_id = 0.
REQ-030 SHALL, for W = 11, req1 with a = 11'h400, b = 11'h400, c0 = 0, t = 1, produce rsp_data = 0, rsp_id = 1.
REQ-031 SHALL, with both valid held continuously and rsp_ready = 1, grant 0,1,0,1 with RR_EN defined and 0,0,0,0 without it.
REQ-032 SHALL, with rsp_ready = 0 for 5 cycles after rsp_valid, keep rsp_valid, rsp_data and rsp_id unchanged and leave both reqi_ready low.
REQ-033 SHALL, with rst_n pulled low at EVAL stage 5 and released, show no rsp_valid; a new req0 then completes normally in W+1 cycles.
REQ-034 SHALL, with W = 1, a = 1, b = 1, c0 = 0, t = 0, produce rsp_data = 1 at cycle 2.

Source files
------------

// File: rtl/maj_chain_sched_pkg.sv
// Shared types for the time-shared majority-chain scheduler.
// Holds the FSM encoding, default chain length and requester id type.
package maj_chain_sched_pkg;

   localparam int W_DEF = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic req_id_t;

   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/maj_chain_sched_maj3_stage.sv
// Single combinational MAJ3 cell shared by every chain stage.
// The running carry is registered by the parent scheduler.
module maj3_stage (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);

   assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/maj_chain_sched.sv
// Two-requester majority-chain scheduler: one MAJ3 stage per cycle.
// Define MAJ_CHAIN_SCHED_RR_EN for round-robin grant; default is fixed priority.
module maj_chain_sched
   import maj_chain_sched_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_c0,
   input  logic         req0_t,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_c0,
   input  logic         req1_t,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_data,
   output req_id_t      rsp_id
);

   localparam int IW = idx_w(W);
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   state_t          state;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            t_q;
   req_id_t         id_q;

   req_id_t         grant_id;
   logic            idle_ok;
   logic            accept;
   logic            maj_y;

`ifdef MAJ_CHAIN_SCHED_RR_EN
   req_id_t         prio;

   // On a tie the requester not granted most recently wins.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid)
         grant_id = prio;
      else if (req1_valid)
         grant_id = 1'b1;
   end
`else
   always_comb begin
      grant_id = 1'b0;
      if (!req0_valid && req1_valid)
         grant_id = 1'b1;
   end
`endif

   assign idle_ok    = rst_n && (state == IDLE);
   assign req0_ready = idle_ok && req0_valid && (grant_id == 1'b0);
   assign req1_ready = idle_ok && req1_valid && (grant_id == 1'b1);
   assign accept     = req0_ready || req1_ready;

   maj3_stage u_maj3 (
      .a (a_q[idx]),
      .b (b_q[idx]),
      .c (carry),
      .y (maj_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         t_q       <= 1'b0;
         id_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 1'b0;
         rsp_id    <= 1'b0;
`ifdef MAJ_CHAIN_SCHED_RR_EN
         prio      <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_q   <= grant_id ? req1_a  : req0_a;
                  b_q   <= grant_id ? req1_b  : req0_b;
                  carry <= grant_id ? req1_c0 : req0_c0;
                  t_q   <= grant_id ? req1_t  : req0_t;
                  id_q  <= grant_id;
                  idx   <= '0;
                  state <= EVAL;
`ifdef MAJ_CHAIN_SCHED_RR_EN
                  prio  <= ~grant_id;
`endif
               end
            end
            EVAL: begin
               carry <= maj_y;
               if (idx == LAST)
                  state <= RESP;
               else
                  idx <= idx + 1'b1;
            end
            RESP: begin
               // First RESP cycle launches the registered response.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= t_q ^ carry;
                  rsp_id    <= id_q;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maj_chain_sched.sv
// Directed bench for maj_chain_sched with a response scoreboard.
// Covers W=11 latency/data, stalls, arbitration, mid-op reset and W=1.
module tb_maj_chain_sched;
   import maj_chain_sched_pkg::*;

   localparam int W = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic req0_c0, req0_t, req1_c0, req1_t;
   logic rsp_valid, rsp_ready, rsp_data;
   req_id_t rsp_id;

   logic u_v0, u_v1, u_r0, u_r1;
   logic [0:0] u_a0, u_b0, u_a1, u_b1;
   logic u_c0, u_t0, u_c1, u_t1;
   logic u_rv, u_rr, u_rd;
   req_id_t u_rid;

   maj_chain_sched #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b),
      .req0_c0(req0_c0), .req0_t(req0_t),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b),
      .req1_c0(req1_c0), .req1_t(req1_t),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id)
   );

   maj_chain_sched #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(u_v0), .req0_ready(u_r0),
      .req0_a(u_a0), .req0_b(u_b0),
      .req0_c0(u_c0), .req0_t(u_t0),
      .req1_valid(u_v1), .req1_ready(u_r1),
      .req1_a(u_a1), .req1_b(u_b1),
      .req1_c0(u_c1), .req1_t(u_t1),
      .rsp_valid(u_rv), .rsp_ready(u_rr),
      .rsp_data(u_rd), .rsp_id(u_rid)
   );

   typedef struct packed {
      logic data;
      logic id;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   function automatic logic model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic c0,
                                  input logic t);
      logic c;
      c = c0;
      for (int k = 0; k < W; k++)
         c = (a[k] & c) | (a[k] & b[k]) | (c & b[k]);
      return t ^ c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c0,
                        input logic t, input bit push);
      int n;
      n = 0;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
         req1_c0 = c0; req1_t = t;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
         req0_c0 = c0; req0_t = t;
      end
      #1;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         tick();
         n++;
      end
      check("accept_ready", id ? req1_ready : req0_ready, 1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req0_b = ~b; req0_c0 = ~c0; req0_t = ~t;
      req1_a = ~a; req1_b = ~b; req1_c0 = ~c0; req1_t = ~t;
      if (push) sb.push_back('{data: model(a, b, c0, t), id: id});
   endtask

   task automatic wait_rsp(input int exp_lat);
      int n;
      exp_t e;
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      check("rsp_latency", n, exp_lat);
      if (rsp_valid) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_id", rsp_id, e.id);
         end else begin
            check("sb_nonempty", 0, 1);
         end
      end
      tick();
   endtask

   initial begin
      logic [W-1:0] a0, b0, a1, b1;
      logic c00, t0, c01, t1, g, exp_g;
      int n, hi;
      exp_t e;

      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_c0 = 0; req0_t = 0;
      req1_a = '0; req1_b = '0; req1_c0 = 0; req1_t = 0;
      u_v0 = 0; u_v1 = 0; u_rr = 1;
      u_a0 = '0; u_b0 = '0; u_c0 = 0; u_t0 = 0;
      u_a1 = '0; u_b1 = '0; u_c1 = 0; u_t1 = 0;
      tick(); tick();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      req0_valid = 0; req1_valid = 0;
      rst_n = 1'b1;
      tick();

      issue(0, 11'h7FF, 11'h000, 0, 0, 1);
      wait_rsp(W + 1);
      issue(1, 11'h400, 11'h400, 0, 1, 1);
      wait_rsp(W + 1);

      for (int i = 0; i < 6; i++) begin
         issue(1'(i), 11'($urandom), 11'($urandom),
               1'($urandom), 1'($urandom), 1);
         wait_rsp(W + 1);
      end

      // Response stall with both requesters knocking.
      issue(1, 11'h155, 11'h0F3, 1, 0, 1);
      rsp_ready = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      check("stall_latency", n, W + 1);
      e = sb.pop_front();
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", rsp_valid, 1);
         check("stall_data", rsp_data, e.data);
         check("stall_id", rsp_id, e.id);
         check("stall_ready", {req0_ready, req1_ready}, 0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("consume_ready", {req0_ready, req1_ready}, 0);
      tick();
      req0_valid = 0; req1_valid = 0;
      tick();

      // Reset in the middle of EVAL drops the operation.
      issue(0, 11'h3A5, 11'h1C7, 1, 1, 0);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_valid", rsp_valid, 0);
      rst_n = 1'b1;
      hi = 0;
      repeat (W + 4) begin
         tick();
         if (rsp_valid) hi++;
      end
      check("midrst_no_rsp", hi, 0);
      issue(0, 11'h2F0, 11'h10F, 0, 1, 1);
      wait_rsp(W + 1);

      // Arbitration with both valid held, pointer fresh from reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a0 = 11'($urandom); b0 = 11'($urandom);
      a1 = 11'($urandom); b1 = 11'($urandom);
      c00 = 1; t0 = 0; c01 = 0; t1 = 1;
      req0_a = a0; req0_b = b0; req0_c0 = c00; req0_t = t0;
      req1_a = a1; req1_b = b1; req1_c0 = c01; req1_t = t1;
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(req0_ready || req1_ready) && n < 20) begin
            tick();
            n++;
         end
         g = req1_ready;
`ifdef MAJ_CHAIN_SCHED_RR_EN
         exp_g = 1'(i);
`else
         exp_g = 1'b0;
`endif
         check("arb_grant", g, exp_g);
         check("arb_one_hot", req0_ready & req1_ready, 0);
         sb.push_back('{data: g ? model(a1, b1, c01, t1)
                                : model(a0, b0, c00, t0), id: g});
         tick();
         check("eval_ready_low", {req0_ready, req1_ready}, 0);
         wait_rsp(W + 1);
      end
      req0_valid = 0; req1_valid = 0;
      tick();

      // Single-stage chain.
      u_a0 = 1'b1; u_b0 = 1'b1; u_c0 = 0; u_t0 = 0; u_v0 = 1;
      #1;
      check("w1_ready", u_r0, 1);
      tick();
      u_v0 = 0;
      n = 0;
      while (!u_rv && n < 20) begin
         tick();
         n++;
      end
      check("w1_latency", n, 2);
      check("w1_data", u_rd, 1);
      check("w1_id", u_rid, 0);
      tick();

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
